cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Arbitrates line-granularity misses from the split L1 I-cache and L1 D-cache onto the single unified L2 port.
- Sits directly downstream of both L1 caches and upstream of L2.
- Carries 16-bit byte addresses and 128-bit (8-word) lines.
- Serves one outstanding transaction at a time and uses round-robin priority when both L1s request together.

Parameters:
- ADDR_W, 16: address width (lc3b_word).
- LINE_W, 128: line width (lc3b_line).
- D_FIRST, 1: on the first contention after reset, 1 grants the D-cache and 0 grants the I-cache.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to the I-cache; valid when i_resp=1.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line writeback request; held until d_resp; never asserted together with d_read.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  writeback line.
- d_rdata  out  LINE_W  line returned to the D-cache; valid when d_resp=1.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- l2_read  out  1  L2 read request.
- l2_write  out  1  L2 write request.
- l2_address  out  ADDR_W  L2 address.
- l2_wdata  out  LINE_W  L2 write data.
- l2_rdata  in  LINE_W  L2 read data; valid with l2_resp.
- l2_resp  in  1  L2 completion.

Behaviour:
- Reset values:
  - Outputs: l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0.
  - State: FSM=IDLE; last_grant = I if D_FIRST=1, else D (so the first contention goes to the D_FIRST winner).
- IDLE state:
  - Evaluates requests each cycle.
  - If only one side requests, that side is granted.
  - If both request, the side opposite last_grant is granted.
  - On grant, these are registered: owner, op (read/write), address, and wdata (D write only).
  - last_grant is updated to the owner.
  - Next state is BUSY.
  - Grant latency is 1 cycle: l2_read or l2_write first appears the cycle after the request is sampled in IDLE.
- BUSY state:
  - Drives l2_read/l2_write, l2_address and l2_wdata from the registers, held stable.
  - Changes in L1 inputs are ignored.
  - On l2_resp=1: l2_rdata is captured into the owner's rdata register, l2_read/l2_write are deasserted in the next cycle, and next state is DONE.
  - No timeout; BUSY waits indefinitely.
- DONE state:
  - Asserts the owner's resp (i_resp or d_resp) for exactly one cycle.
  - The other side's resp stays 0; the owner's rdata is valid.
  - Next state is IDLE unconditionally.
  - The L1 drops its request in the same cycle it sees resp, so IDLE never re-grants a completed request.
- rdata registers hold their last captured value until the next capture.
- For a D write, d_rdata is not updated.
- Minimum transaction: request sampled (IDLE) → BUSY (≥1 cycle) → DONE → IDLE, i.e. 3 cycles with a 1-cycle L2 response.
- Boundary conditions:
  - A request arriving during BUSY or DONE waits and is evaluated in the next IDLE.
  - The loser of contention is guaranteed the next grant; there is no starvation.
  - l2_resp while in IDLE or DONE is ignored: no state change, no resp pulse.
  - reset asserted mid-BUSY/DONE: everything returns to reset values next cycle, and the in-flight transaction is abandoned with no resp.
  - d_read and d_write both high is illegal; if it occurs, the request is treated as a write.

Test Plan:
- Isolated I read: i_read=1, i_address=0x1230; L2 returns 0xDEAD…BEEF after 3 cycles → l2_read=1 with l2_address=0x1230 from cycle+1; i_resp pulses once with i_rdata=0xDEAD…BEEF; d_resp stays 0.
- D writeback: d_write=1, d_address=0x4560, d_wdata=0xA5A5…A5 → l2_write=1, l2_wdata=0xA5A5…A5; d_resp pulses once; d_rdata unchanged.
- Contention after reset with D_FIRST=1: i_read and d_read both asserted continuously → D is served first, then I, then D again (strict alternation); each resp is exactly one cycle.
- Mid-transaction input change: during BUSY, d_address is changed 0x1000→0x2000 → l2_address stays 0x1000 until l2_resp.
- Spurious l2_resp in IDLE with no requests → no i_resp/d_resp, and l2_read/l2_write stay 0.
- Reset during BUSY: reset is pulsed 2 cycles into an I read → l2_read=0 next cycle, no i_resp; a re-issued i_read completes normally.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the cache arbiter and the unified L2.
// The arbiter uses the "slave" view: it accepts L1 requests and issues L2
// requests. The "master" view is the environment: both L1 caches plus L2.
interface cache_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    // L1 I-cache side
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // L1 D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // Unified L2 side
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output l2_read, l2_write, l2_address, l2_wdata,
        input  l2_rdata, l2_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata,
        output l2_rdata, l2_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Cache arbiter: funnels line misses/writebacks from the split L1 I/D caches
// onto the single unified L2 port, one transaction at a time, with
// round-robin priority between the two L1s when both request together.
module cache_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter bit D_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    cache_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // last_grant starts on the side that should lose the first contention
    localparam logic LAST_GRANT_RST = D_FIRST ? OWNER_I : OWNER_D;

    state_t            state_r,      state_s;
    logic              owner_r,      owner_s;
    logic              op_write_r,   op_write_s;
    logic              last_grant_r, last_grant_s;
    logic [ADDR_W-1:0] addr_r,       addr_s;
    logic [LINE_W-1:0] wdata_r,      wdata_s;
    logic [LINE_W-1:0] i_rdata_r,    i_rdata_s;
    logic [LINE_W-1:0] d_rdata_r,    d_rdata_s;
    logic              l2_read_r,    l2_read_s;
    logic              l2_write_r,   l2_write_s;
    logic              i_resp_r,     i_resp_s;
    logic              d_resp_r,     d_resp_s;

    logic              i_req_s;
    logic              d_req_s;
    logic              grant_d_s;
    logic              d_is_write_s;

    // Request decode and round-robin choice of the winner in IDLE
    always_comb begin
        i_req_s      = bus.i_read;
        d_req_s      = bus.d_read | bus.d_write;
        // d_read together with d_write is illegal; the write wins
        d_is_write_s = bus.d_write;
        if (i_req_s && d_req_s) begin
            grant_d_s = (last_grant_r == OWNER_I);
        end else begin
            grant_d_s = d_req_s;
        end
    end

    // Next-state and next-register logic for the IDLE/BUSY/DONE controller
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        op_write_s   = op_write_r;
        last_grant_s = last_grant_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        i_rdata_s    = i_rdata_r;
        d_rdata_s    = d_rdata_r;
        l2_read_s    = l2_read_r;
        l2_write_s   = l2_write_r;
        i_resp_s     = 1'b0;
        d_resp_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_req_s || d_req_s) begin
                    owner_s      = grant_d_s;
                    last_grant_s = grant_d_s;
                    if (grant_d_s) begin
                        op_write_s = d_is_write_s;
                        addr_s     = bus.d_address;
                        if (d_is_write_s) begin
                            wdata_s = bus.d_wdata;
                        end else begin
                            wdata_s = wdata_r;
                        end
                    end else begin
                        op_write_s = 1'b0;
                        addr_s     = bus.i_address;
                        wdata_s    = wdata_r;
                    end
                    l2_write_s = grant_d_s & d_is_write_s;
                    l2_read_s  = ~(grant_d_s & d_is_write_s);
                    state_s    = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // L1 inputs are not looked at here; the latched request is held
                if (bus.l2_resp) begin
                    l2_read_s  = 1'b0;
                    l2_write_s = 1'b0;
                    state_s    = ST_DONE;
                    if (owner_r == OWNER_D) begin
                        d_resp_s = 1'b1;
                        if (!op_write_r) begin
                            d_rdata_s = bus.l2_rdata;
                        end else begin
                            d_rdata_s = d_rdata_r;
                        end
                    end else begin
                        i_resp_s  = 1'b1;
                        i_rdata_s = bus.l2_rdata;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end

            ST_DONE: begin
                // resp is high for this single cycle; the L1 drops its request now
                state_s = ST_IDLE;
            end

            default: begin
                state_s    = ST_IDLE;
                l2_read_s  = 1'b0;
                l2_write_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_I;
            op_write_r   <= 1'b0;
            last_grant_r <= LAST_GRANT_RST;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {LINE_W{1'b0}};
            i_rdata_r    <= {LINE_W{1'b0}};
            d_rdata_r    <= {LINE_W{1'b0}};
            l2_read_r    <= 1'b0;
            l2_write_r   <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            op_write_r   <= op_write_s;
            last_grant_r <= last_grant_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            i_rdata_r    <= i_rdata_s;
            d_rdata_r    <= d_rdata_s;
            l2_read_r    <= l2_read_s;
            l2_write_r   <= l2_write_s;
            i_resp_r     <= i_resp_s;
            d_resp_r     <= d_resp_s;
        end
    end

    assign bus.l2_read    = l2_read_r;
    assign bus.l2_write   = l2_write_r;
    assign bus.l2_address = addr_r;
    assign bus.l2_wdata   = wdata_r;
    assign bus.i_rdata    = i_rdata_r;
    assign bus.i_resp     = i_resp_r;
    assign bus.d_rdata    = d_rdata_r;
    assign bus.d_resp     = d_resp_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed L1 requests push expected L2
// transactions and expected L1 responses; an L2 responder and an L1 response
// monitor pop and compare independently of the stimulus.
`timescale 1ns/1ps
module tb_cache_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int BUDGET = 60;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
        int                lat;
    } l2_exp_t;

    logic clk;
    logic reset;
    logic              l2_resp_m;
    logic [LINE_W-1:0] l2_rdata_m;
    logic              spur_resp;
    logic [LINE_W-1:0] spur_data;

    int checks   = 0;
    int failures = 0;

    l2_exp_t           l2_q[$];
    logic [LINE_W-1:0] i_exp_q[$];
    logic [LINE_W-1:0] d_exp_q[$];
    bit prev_i = 1'b0;
    bit prev_d = 1'b0;

    localparam logic [LINE_W-1:0] D1   = 128'hD1D1_0000_1111_2222_3333_4444_5555_D1D1;
    localparam logic [LINE_W-1:0] D2   = 128'hD2D2_6666_7777_8888_9999_AAAA_BBBB_D2D2;
    localparam logic [LINE_W-1:0] I1   = 128'h1A1A_CCCC_DDDD_EEEE_FFFF_0101_0202_1A1A;
    localparam logic [LINE_W-1:0] I2   = 128'h2B2B_0303_0404_0505_0606_0707_0808_2B2B;
    localparam logic [LINE_W-1:0] DB   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [LINE_W-1:0] P1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LINE_W-1:0] A5   = {16{8'hA5}};
    localparam logic [LINE_W-1:0] X5A  = {16{8'h5A}};
    localparam logic [LINE_W-1:0] JUNK = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [LINE_W-1:0] CODE = 128'hC0DE_C0DE_1234_5678_9ABC_DEF0_C0DE_C0DE;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .D_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.l2_resp  = l2_resp_m | spur_resp;
    assign bus.l2_rdata = l2_rdata_m | spur_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_l2(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata,
                           input int lat);
        l2_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
        l2_q.push_back(e);
    endtask

    task automatic i_req(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] exp_rdata);
        int n;
        bit got;
        n = 0; got = 1'b0;
        @(negedge clk);
        i_exp_q.push_back(exp_rdata);
        bus.i_read    = 1'b1;
        bus.i_address = addr;
        while (!got && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (bus.i_resp === 1'b1) got = 1'b1;
        end
        bus.i_read = 1'b0;
        chk("i_resp_within_budget", {127'd0, got}, 128'd1);
    endtask

    task automatic d_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] exp_rdata);
        int n;
        bit got;
        n = 0; got = 1'b0;
        @(negedge clk);
        d_exp_q.push_back(exp_rdata);
        bus.d_read    = rd;
        bus.d_write   = wr;
        bus.d_address = addr;
        bus.d_wdata   = wdata;
        while (!got && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (bus.d_resp === 1'b1) got = 1'b1;
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        chk("d_resp_within_budget", {127'd0, got}, 128'd1);
    endtask

    // L2 responder: checks each new L2 request against the expected queue and answers after lat cycles
    initial begin
        l2_exp_t e;
        bit aborted;
        l2_resp_m  = 1'b0;
        l2_rdata_m = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (bus.l2_read === 1'b1 || bus.l2_write === 1'b1)) begin
                if (l2_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_l2_request: got addr %h with no expected transaction", bus.l2_address);
                    e.wr = bus.l2_write; e.addr = bus.l2_address; e.wdata = bus.l2_wdata;
                    e.rdata = '0; e.lat = 1;
                end else begin
                    e = l2_q.pop_front();
                    chk("l2_write", {127'd0, bus.l2_write}, {127'd0, e.wr});
                    chk("l2_read", {127'd0, bus.l2_read}, {127'd0, ~e.wr});
                    chk("l2_address", {112'd0, bus.l2_address}, {112'd0, e.addr});
                    if (e.wr) chk("l2_wdata", bus.l2_wdata, e.wdata);
                end
                aborted = 1'b0;
                for (int k = 1; k < e.lat && !aborted; k++) begin
                    @(negedge clk);
                    if (reset === 1'b1 || !(bus.l2_read === 1'b1 || bus.l2_write === 1'b1)) begin
                        aborted = 1'b1;
                    end else begin
                        chk("l2_address_hold", {112'd0, bus.l2_address}, {112'd0, e.addr});
                    end
                end
                if (!aborted) begin
                    l2_rdata_m = e.rdata;
                    l2_resp_m  = 1'b1;
                    @(negedge clk);
                    l2_resp_m  = 1'b0;
                    l2_rdata_m = '0;
                    chk("l2_req_dropped", {127'd0, bus.l2_read | bus.l2_write}, 128'd0);
                end
            end
        end
    end

    // L1 response monitor: pops expected rdata whenever a resp pulse is seen
    initial begin
        forever begin
            @(negedge clk);
            if (bus.i_resp === 1'b1) begin
                chk("i_resp_single_cycle", {127'd0, prev_i}, 128'd0);
                chk("resp_exclusive", {127'd0, bus.d_resp}, 128'd0);
                if (i_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_i_resp: got i_resp=1 expected no response");
                end else begin
                    chk("i_rdata", bus.i_rdata, i_exp_q.pop_front());
                end
            end
            if (bus.d_resp === 1'b1) begin
                chk("d_resp_single_cycle", {127'd0, prev_d}, 128'd0);
                if (d_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_d_resp: got d_resp=1 expected no response");
                end else begin
                    chk("d_rdata", bus.d_rdata, d_exp_q.pop_front());
                end
            end
            prev_i = (bus.i_resp === 1'b1);
            prev_d = (bus.d_resp === 1'b1);
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        spur_resp = 1'b0; spur_data = '0;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_l2_read", {127'd0, bus.l2_read}, 128'd0);
        chk("rst_l2_write", {127'd0, bus.l2_write}, 128'd0);
        chk("rst_l2_address", {112'd0, bus.l2_address}, 128'd0);
        chk("rst_l2_wdata", bus.l2_wdata, 128'd0);
        chk("rst_i_resp", {127'd0, bus.i_resp}, 128'd0);
        chk("rst_d_resp", {127'd0, bus.d_resp}, 128'd0);
        chk("rst_i_rdata", bus.i_rdata, 128'd0);
        chk("rst_d_rdata", bus.d_rdata, 128'd0);
        reset = 1'b0;

        // Contention right after reset: D first, then strict alternation
        push_l2(1'b0, 16'h1110, '0, D1, 1);
        push_l2(1'b0, 16'h2220, '0, I1, 1);
        push_l2(1'b0, 16'h1130, '0, D2, 1);
        push_l2(1'b0, 16'h2240, '0, I2, 1);
        fork
            begin
                d_req(1'b1, 1'b0, 16'h1110, '0, D1);
                d_req(1'b1, 1'b0, 16'h1130, '0, D2);
            end
            begin
                i_req(16'h2220, I1);
                i_req(16'h2240, I2);
            end
        join

        // Isolated I read with 3-cycle L2 latency; grant appears exactly one cycle later
        push_l2(1'b0, 16'h1230, '0, DB, 3);
        fork
            i_req(16'h1230, DB);
            begin
                @(negedge clk);
                chk("grant_not_early", {127'd0, bus.l2_read}, 128'd0);
                @(negedge clk);
                chk("grant_latency_l2_read", {127'd0, bus.l2_read}, 128'd1);
                chk("grant_latency_addr", {112'd0, bus.l2_address}, {112'd0, 16'h1230});
            end
        join

        // D read whose address input changes mid-BUSY
        push_l2(1'b0, 16'h1000, '0, P1, 4);
        fork
            d_req(1'b1, 1'b0, 16'h1000, '0, P1);
            begin
                repeat (3) @(negedge clk);
                bus.d_address = 16'h2000;
            end
        join

        // D writeback: d_rdata keeps the previous read line
        push_l2(1'b1, 16'h4560, A5, JUNK, 2);
        d_req(1'b0, 1'b1, 16'h4560, A5, P1);

        // Illegal d_read+d_write is handled as a write
        push_l2(1'b1, 16'h7770, X5A, JUNK, 1);
        d_req(1'b1, 1'b1, 16'h7770, X5A, P1);

        // Spurious l2_resp in IDLE
        @(negedge clk);
        spur_resp = 1'b1; spur_data = '1;
        @(negedge clk);
        spur_resp = 1'b0; spur_data = '0;
        for (int c = 0; c < 3; c++) begin
            chk("spur_l2_read", {127'd0, bus.l2_read}, 128'd0);
            chk("spur_l2_write", {127'd0, bus.l2_write}, 128'd0);
            chk("spur_i_resp", {127'd0, bus.i_resp}, 128'd0);
            chk("spur_d_resp", {127'd0, bus.d_resp}, 128'd0);
            @(negedge clk);
        end
        chk("spur_i_rdata_kept", bus.i_rdata, DB);
        chk("spur_d_rdata_kept", bus.d_rdata, P1);

        // Reset two cycles into an I read abandons it
        push_l2(1'b0, 16'h3330, '0, JUNK, 20);
        bus.i_read = 1'b1; bus.i_address = 16'h3330;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; bus.i_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_l2_read", {127'd0, bus.l2_read}, 128'd0);
        chk("mid_rst_l2_address", {112'd0, bus.l2_address}, 128'd0);
        chk("mid_rst_l2_wdata", bus.l2_wdata, 128'd0);
        chk("mid_rst_i_resp", {127'd0, bus.i_resp}, 128'd0);
        chk("mid_rst_i_rdata", bus.i_rdata, 128'd0);
        chk("mid_rst_d_rdata", bus.d_rdata, 128'd0);
        repeat (3) @(negedge clk);

        // Re-issued I read completes normally
        push_l2(1'b0, 16'h3330, '0, CODE, 1);
        i_req(16'h3330, CODE);

        repeat (3) @(negedge clk);
        chk("l2_queue_drained", l2_q.size(), 128'd0);
        chk("i_queue_drained", i_exp_q.size(), 128'd0);
        chk("d_queue_drained", d_exp_q.size(), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
